mm_stream_engine: RTL and testbench
===================================

Name: mm_stream_engine

Overview:
Parametrised successor to the fixed 8-bit, UART-fed matrix-multiply datapath. It accepts a runtime matrix size N (1..MAX_N) and loads A then B (row-major) over a valid/ready input stream. It computes C = A x B with one pipelined multiply-accumulate unit and emits C row-major on a valid/ready output stream. It sits between the UART receiver/transmitter adapters and replaces the separate sequencer, memory and MAC trio.

Parameters:
DATA_W, 8, operand width in bits (unsigned)
MAX_N, 8, maximum matrix dimension; sets internal A/B storage of MAX_N*MAX_N words each
ACC_W, 2*DATA_W+$clog2(MAX_N), accumulator width; sized so no overflow occurs before output narrowing
SAT, 1, 1 = saturate result to DATA_W on output; 0 = keep low DATA_W bits (truncate)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin job; sampled only in IDLE
size  in  $clog2(MAX_N+1)  N for the job, latched on accepted start
in_data  in  DATA_W  A/B element stream
in_valid  in  1  in_data valid
in_ready  out  1  engine accepts in_data (high only in LOAD_A/LOAD_B)
out_data  out  DATA_W  C element, row-major
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last C element is accepted
err  out  1  one-cycle pulse when start is given with size 0 or size > MAX_N

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE. in_ready, out_valid, busy, done and err are 0. out_data is 0. Counters i, j, k and the accumulator are 0. A/B storage is not cleared.
- Input transfer occurs when in_valid and in_ready are both high. Output transfer occurs when out_valid and out_ready are both high.
- IDLE:
  - start with a legal size: latch N, clear counters, go to LOAD_A.
  - start with an illegal size: pulse err, stay in IDLE.
- LOAD_A: in_ready=1. Each transfer writes A[r][c] with c incrementing first. After N*N transfers, go to LOAD_B.
- LOAD_B: same as LOAD_A for B. After the last transfer go to MAC with i=j=k=0, one cycle after the final handshake.
- MAC:
  - Each cycle reads A[i][k] and B[k][j] and computes the product into a one-stage product register.
  - The accumulator adds the product the following cycle. acc is cleared at the first product of each element.
  - k runs 0..N-1. The element is ready N+1 cycles after MAC entry (pipeline drain). Then go to EMIT.
- EMIT:
  - out_valid=1. out_data = SAT ? min(acc, 2^DATA_W-1) : acc[DATA_W-1:0].
  - out_data and out_valid hold stable until out_ready.
  - On transfer, advance j; when j wraps, advance i. If elements remain, go back to MAC. After element (N-1,N-1), go to DONE.
- DONE: pulse done for one cycle, go to IDLE.
- start while busy is ignored (no err).
- in_valid outside LOAD states is ignored; in_ready stays 0 there.
- N=1 is legal: a single element, MAC lasts 2 cycles.
- Arithmetic is unsigned. The product is 2*DATA_W bits, zero-extended to ACC_W before accumulation.
- rst_n asserted mid-job aborts the job immediately. No done pulse is produced, and the next job requires a fresh start.

Decomposition:
- Package mm_pkg holds:
  - the state enum (IDLE, LOAD_A, LOAD_B, MAC, EMIT, DONE);
  - the width function for the size/index fields;
  - the saturation helper function.
- Sub-module mm_mac holds the product register, the accumulator with clear/enable, and the output narrowing (SAT mode).
- The FSM, counters and storage live in mm_stream_engine.

Test Plan:
- N=2, A=[1 2;3 4], B=[5 6;7 8], out_ready always 1 -> out stream 19, 22, 43, 50, then one done pulse; busy low afterwards.
- SAT=1, N=2, all A/B = 255 -> every C element is 255 (raw 130050).
- SAT=0, N=2, all A/B = 255 -> every C element is 2 (130050 mod 256).
- Repeat the 2x2 case with out_ready toggling 1/0 randomly and in_valid gaps -> same 19, 22, 43, 50; out_data stable while out_valid=1 and out_ready=0.
- start with size=0, then size=MAX_N+1 -> err pulses once each; busy stays 0; no in_ready.
- Drop rst_n during MAC of a 3x3 job, release it, then run N=1 with A=3, B=4 -> all outputs 0 during reset; the new job emits 12 and pulses done.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared types and helpers for the streaming matrix-multiply engine.
// Holds the FSM state encoding, index-width sizing and the saturation test.
package mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        MAC,
        EMIT,
        DONE
    } state_t;

    // Width of a field that must hold values 0..max_n inclusive.
    function automatic int idx_w(input int max_n);
        return $clog2(max_n + 1);
    endfunction

    // True when value does not fit in the low 'width' bits.
    function automatic logic exceeds(input logic [63:0] value, input int width);
        return (value >> width) != 64'd0;
    endfunction

endpackage

// File: rtl/mm_mac.sv
// Single pipelined multiply-accumulate: one product register stage, then the
// accumulator, then narrowing of the accumulated value to the output width.
module mm_mac
    import mm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 19,
    parameter bit SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic              i_prod_en,
    input  logic              i_acc_en,
    input  logic              i_acc_clr,
    output logic [DATA_W-1:0] o_data
);

    logic [2*DATA_W-1:0] r_prod;
    logic [ACC_W-1:0]    r_acc;
    logic [2*DATA_W-1:0] w_a_ext;
    logic [2*DATA_W-1:0] w_b_ext;
    logic                w_over;

    assign w_a_ext = {{DATA_W{1'b0}}, i_a};
    assign w_b_ext = {{DATA_W{1'b0}}, i_b};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            if (i_prod_en)
                r_prod <= w_a_ext * w_b_ext;
            if (i_acc_en)
                r_acc <= i_acc_clr ? ACC_W'(r_prod) : r_acc + ACC_W'(r_prod);
        end
    end

    assign w_over = exceeds(64'(r_acc), DATA_W);
    assign o_data = (SAT && w_over) ? {DATA_W{1'b1}} : r_acc[DATA_W-1:0];

endmodule

// File: rtl/mm_stream_engine.sv
// Streaming C = A x B engine: loads A then B row-major over a valid/ready
// input, computes each C element with one MAC and emits C row-major.
module mm_stream_engine
    import mm_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(MAX_N),
    parameter bit SAT    = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [idx_w(MAX_N)-1:0]    size,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam int SZ_W  = idx_w(MAX_N);
    localparam int AW    = (MAX_N > 1) ? $clog2(MAX_N*MAX_N) : 1;
    localparam int DEPTH = MAX_N*MAX_N;

    state_t            r_state;
    state_t            w_next;
    logic [SZ_W-1:0]   r_n;
    logic [SZ_W-1:0]   r_i;
    logic [SZ_W-1:0]   r_j;
    logic [SZ_W-1:0]   r_k;
    logic              r_err;
    logic [DATA_W-1:0] r_mem_a [DEPTH];
    logic [DATA_W-1:0] r_mem_b [DEPTH];

    logic              w_size_ok;
    logic              w_last_j;
    logic              w_last_ij;
    logic [AW-1:0]     w_wr_addr;
    logic [AW-1:0]     w_rd_a;
    logic [AW-1:0]     w_rd_b;
    logic [DATA_W-1:0] w_mac_data;
    logic              w_prod_en;
    logic              w_acc_en;
    logic              w_acc_clr;

    assign w_size_ok = (size != '0) && (size <= SZ_W'(MAX_N));
    assign w_last_j  = (r_j == r_n - SZ_W'(1));
    assign w_last_ij = w_last_j && (r_i == r_n - SZ_W'(1));

    assign w_wr_addr = AW'(int'(r_i) * MAX_N + int'(r_j));
    assign w_rd_a    = AW'(int'(r_i) * MAX_N + int'(r_k));
    assign w_rd_b    = AW'(int'(r_k) * MAX_N + int'(r_j));

    // Products issue for k < N; accumulation trails by one cycle, so MAC
    // spends N+1 cycles per element and clears acc on the first product.
    assign w_prod_en = (r_state == MAC) && (r_k < r_n);
    assign w_acc_en  = (r_state == MAC) && (r_k != '0);
    assign w_acc_clr = (r_k == SZ_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        out_data  = '0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start && w_size_ok)
                    w_next = LOAD_A;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid && w_last_ij)
                    w_next = LOAD_B;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid && w_last_ij)
                    w_next = MAC;
            end
            MAC: begin
                if (r_k == r_n)
                    w_next = EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_data  = w_mac_data;
                if (out_ready)
                    w_next = w_last_ij ? DONE : MAC;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= (r_state == IDLE) && start && !w_size_ok;
            case (r_state)
                IDLE: begin
                    if (start && w_size_ok) begin
                        r_n <= size;
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                LOAD_A, LOAD_B, EMIT: begin
                    if ((r_state == EMIT) ? out_ready : in_valid) begin
                        if (w_last_j) begin
                            r_j <= '0;
                            r_i <= w_last_ij ? '0 : r_i + SZ_W'(1);
                        end else begin
                            r_j <= r_j + SZ_W'(1);
                        end
                    end
                end
                MAC: r_k <= (r_k == r_n) ? '0 : r_k + SZ_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: operand storage is deliberately left out of reset; every word is
    // rewritten by the load phase before the MAC can read it.
    always_ff @(posedge clk) begin
        if (in_valid && r_state == LOAD_A)
            r_mem_a[w_wr_addr] <= in_data;
        if (in_valid && r_state == LOAD_B)
            r_mem_b[w_wr_addr] <= in_data;
    end

    assign err = r_err;

    mm_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .SAT    (SAT)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_a       (r_mem_a[w_rd_a]),
        .i_b       (r_mem_b[w_rd_b]),
        .i_prod_en (w_prod_en),
        .i_acc_en  (w_acc_en),
        .i_acc_clr (w_acc_clr),
        .o_data    (w_mac_data)
    );

endmodule

// File: tb/tb_mm_stream_engine.sv
// Scoreboard bench for mm_stream_engine: a saturating and a truncating
// instance share all inputs; a monitor pops expected pairs on each output.
module tb_mm_stream_engine;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 8;
    localparam int SZ_W   = $clog2(MAX_N + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [SZ_W-1:0]   size = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;

    logic              in_ready_s, out_valid_s, busy_s, done_s, err_s;
    logic [DATA_W-1:0] out_data_s;
    logic              in_ready_t, out_valid_t, busy_t, done_t, err_t;
    logic [DATA_W-1:0] out_data_t;

    typedef struct {
        logic [DATA_W-1:0] sat_v;
        logic [DATA_W-1:0] trunc_v;
    } exp_t;

    exp_t              sb_q[$];
    logic [DATA_W-1:0] vec [0:127];
    int                checks = 0;
    int                failures = 0;
    bit                rand_ready = 1'b0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;

    mm_stream_engine #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SAT(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
        .out_data(out_data_s), .out_valid(out_valid_s), .out_ready(out_ready),
        .busy(busy_s), .done(done_s), .err(err_s)
    );

    mm_stream_engine #(.DATA_W(DATA_W), .MAX_N(MAX_N), .SAT(1'b0)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start), .size(size),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_t),
        .out_data(out_data_t), .out_valid(out_valid_t), .out_ready(out_ready),
        .busy(busy_t), .done(done_t), .err(err_t)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: samples on the falling edge, where inputs are settled for the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid_s), 32'd1);
                check("hold_data", 32'(out_data_s), 32'(prev_data));
            end
            if (out_valid_s && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got %0d with empty scoreboard", out_data_s);
                end else begin
                    e = sb_q.pop_front();
                    check("c_sat", 32'(out_data_s), 32'(e.sat_v));
                    check("c_trunc", 32'(out_data_t), 32'(e.trunc_v));
                end
            end
            prev_stall = out_valid_s && !out_ready;
            prev_data  = out_data_s;
        end
    end

    task automatic push_exp(input int sat_v, input int trunc_v);
        exp_t e;
        e.sat_v   = DATA_W'(sat_v);
        e.trunc_v = DATA_W'(trunc_v);
        sb_q.push_back(e);
    endtask

    task automatic kick(input int n);
        start = 1'b1;
        size  = SZ_W'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic feed(input int n, input bit gaps);
        int wait_cnt;
        for (int e = 0; e < 2*n*n; e++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = vec[e];
            wait_cnt = 0;
            @(negedge clk);
            while (!in_ready_s && wait_cnt < 100) begin
                wait_cnt++;
                @(negedge clk);
            end
            if (!in_ready_s) begin
                checks++;
                failures++;
                $display("FAIL in_ready_timeout: element %0d never accepted", e);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (cyc < 2000 && !seen) begin
            @(negedge clk);
            if (done_s) begin
                seen = 1'b1;
                check({name, "_done_t"}, 32'(done_t), 32'd1);
            end
            cyc++;
        end
        check({name, "_done"}, 32'(seen), 32'd1);
        @(negedge clk);
        check({name, "_done_pulse"}, 32'(done_s), 32'd0);
        check({name, "_busy_after"}, 32'(busy_s), 32'd0);
        check({name, "_drained"}, 32'(sb_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input string name, input int n, input bit gaps);
        kick(n);
        feed(n, gaps);
        wait_done(name);
    endtask

    task automatic err_case(input string name, input int sz);
        start = 1'b1;
        size  = SZ_W'(sz);
        @(negedge clk);
        check({name, "_busy_pre"}, 32'(busy_s), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check({name, "_err"}, 32'(err_s), 32'd1);
        check({name, "_err_t"}, 32'(err_t), 32'd1);
        check({name, "_busy"}, 32'(busy_s), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready_s), 32'd0);
        @(negedge clk);
        check({name, "_err_pulse"}, 32'(err_s), 32'd0);
        check({name, "_busy2"}, 32'(busy_s), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        check({name, "_busy"}, 32'(busy_s), 32'd0);
        check({name, "_in_ready"}, 32'(in_ready_s), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid_s), 32'd0);
        check({name, "_out_data"}, 32'(out_data_s), 32'd0);
        check({name, "_done"}, 32'(done_s), 32'd0);
        check({name, "_err"}, 32'(err_s), 32'd0);
        check({name, "_busy_t"}, 32'(busy_t), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A = [1 2; 3 4], B = [5 6; 7 8]
        for (int e = 0; e < 8; e++) vec[e] = DATA_W'(e + 1);
        push_exp(19, 19); push_exp(22, 22); push_exp(43, 43); push_exp(50, 50);
        run_job("mm2x2", 2, 1'b0);

        // All 255: raw 130050 saturates to 255, truncates to 2
        for (int e = 0; e < 8; e++) vec[e] = 8'd255;
        for (int e = 0; e < 4; e++) push_exp(255, 2);
        run_job("mm_max", 2, 1'b0);

        // Back-pressure and input gaps
        for (int e = 0; e < 8; e++) vec[e] = DATA_W'(e + 1);
        push_exp(19, 19); push_exp(22, 22); push_exp(43, 43); push_exp(50, 50);
        rand_ready = 1'b1;
        run_job("mm_bp", 2, 1'b1);
        rand_ready = 1'b0;

        err_case("err_size0", 0);
        err_case("err_big", MAX_N + 1);

        // 3x3 job aborted by reset during MAC
        for (int e = 0; e < 18; e++) vec[e] = DATA_W'(e + 2);
        kick(3);
        feed(3, 1'b0);
        @(negedge clk);
        check("abort_busy_mac", 32'(busy_s), 32'd1);
        check("abort_no_out", 32'(out_valid_s), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("abort");
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("abort_hold");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle", 32'(busy_s), 32'd0);

        vec[0] = 8'd3;
        vec[1] = 8'd4;
        push_exp(12, 12);
        run_job("mm1x1", 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
